// File: rtl/alu_cmd_serializer.sv
// alu_cmd_serializer: turns one ALU command (operands, opcode, CRC) into a
// bit-serial frame of 11-bit packets: up to eight DATA packets carrying the
// operand bytes, then one CMD packet carrying the opcode and a CRC-4, then
// GAP_CYCLES idle-high cycles. All outputs come straight from flops so the
// serial line never glitches.
module alu_cmd_serializer #(
    parameter int GAP_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  op,
    input  logic [3:0]  n_data,
    input  logic        crc_flip,
    output logic        sin,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND_DATA,
        SEND_CTL,
        GAP
    } state_t;

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [3:0] STOP_BIT = 4'd10;

    // CRC-4, x^4+x+1, init 0, MSB first over the full 68-bit message
    function automatic logic [3:0] crc4(input logic [67:0] msg);
        logic [3:0] c;
        logic       fb;
        c = 4'h0;
        for (int i = 67; i >= 0; i--) begin
            fb = c[3] ^ msg[i];
            c  = {c[2:0], 1'b0} ^ {2'b00, fb, fb};
        end
        return c;
    endfunction

    state_t         state_q, state_d;
    logic [3:0]     bit_cnt_q, bit_cnt_d;
    logic [2:0]     pkt_cnt_q, pkt_cnt_d;
    logic [GW-1:0]  gap_cnt_q, gap_cnt_d;
    logic [31:0]    a_q, a_d;
    logic [31:0]    b_q, b_d;
    logic [2:0]     op_q, op_d;
    logic           crc_flip_q, crc_flip_d;
    logic [3:0]     n_eff_q, n_eff_d;
    logic [3:0]     crc_q, crc_d;
    logic           sin_q, sin_d;
    logic           req_ready_q, req_ready_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           accept;
    logic [7:0]     payload;
    logic [2:0]     payload_idx;

    // Next-state logic: capture on accept, then walk bits, packets and gap
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        pkt_cnt_d  = pkt_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        crc_flip_d = crc_flip_q;
        n_eff_d    = n_eff_q;
        crc_d      = crc_q;
        accept     = req_valid && req_ready_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d    = LOAD;
                    a_d        = a;
                    b_d        = b;
                    op_d       = op;
                    crc_flip_d = crc_flip;
                    n_eff_d    = (n_data > 4'd8) ? 4'd8 : n_data;
                    crc_d      = crc4({b, a, 1'b1, op});
                    bit_cnt_d  = 4'd0;
                    pkt_cnt_d  = 3'd0;
                    gap_cnt_d  = '0;
                end
            end
            LOAD: begin
                state_d   = (n_eff_q != 4'd0) ? SEND_DATA : SEND_CTL;
                bit_cnt_d = 4'd0;
                pkt_cnt_d = 3'd0;
            end
            SEND_DATA: begin
                if (bit_cnt_q == STOP_BIT) begin
                    bit_cnt_d = 4'd0;
                    if ({1'b0, pkt_cnt_q} == n_eff_q - 4'd1) begin
                        state_d   = SEND_CTL;
                        pkt_cnt_d = 3'd0;
                    end else begin
                        pkt_cnt_d = pkt_cnt_q + 3'd1;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
            end
            SEND_CTL: begin
                if (bit_cnt_q == STOP_BIT) begin
                    bit_cnt_d = 4'd0;
                    gap_cnt_d = '0;
                    state_d   = (GAP_CYCLES == 0) ? IDLE : GAP;
                end else begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
            end
            GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d   = IDLE;
                    gap_cnt_d = '0;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode from next-state values so every output is a flop
    always_comb begin
        payload     = 8'h00;
        payload_idx = 3'(4'd9 - bit_cnt_d);
        sin_d       = 1'b1;

        if (state_d == SEND_CTL) begin
            payload = {1'b0, op_q, crc_q ^ {4{crc_flip_q}}};
        end else begin
            case (pkt_cnt_d)
                3'd0:    payload = b_q[31:24];
                3'd1:    payload = b_q[23:16];
                3'd2:    payload = b_q[15:8];
                3'd3:    payload = b_q[7:0];
                3'd4:    payload = a_q[31:24];
                3'd5:    payload = a_q[23:16];
                3'd6:    payload = a_q[15:8];
                default: payload = a_q[7:0];
            endcase
        end

        if (state_d == SEND_DATA || state_d == SEND_CTL) begin
            case (bit_cnt_d)
                4'd0:    sin_d = 1'b0;
                4'd1:    sin_d = (state_d == SEND_CTL);
                4'd10:   sin_d = 1'b1;
                default: sin_d = payload[payload_idx];
            endcase
        end

        busy_d      = (state_d != IDLE);
        req_ready_d = (state_d == IDLE);
        done_d      = ((GAP_CYCLES > 0) && state_d == GAP && gap_cnt_d == GAP_LAST) ||
                      ((GAP_CYCLES == 0) && state_d == SEND_CTL && bit_cnt_d == STOP_BIT);
    end

    // State, captured command and registered outputs; reset aborts any frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bit_cnt_q   <= 4'd0;
            pkt_cnt_q   <= 3'd0;
            gap_cnt_q   <= '0;
            a_q         <= 32'h0;
            b_q         <= 32'h0;
            op_q        <= 3'd0;
            crc_flip_q  <= 1'b0;
            n_eff_q     <= 4'd0;
            crc_q       <= 4'h0;
            sin_q       <= 1'b1;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            pkt_cnt_q   <= pkt_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            crc_flip_q  <= crc_flip_d;
            n_eff_q     <= n_eff_d;
            crc_q       <= crc_d;
            sin_q       <= sin_d;
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign req_ready = req_ready_q;
    assign sin       = sin_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: doc/alu_cmd_serializer.md
ALU_CMD_SERIALIZER -- requirements
Module: alu_cmd_serializer

Interface
REQ-001 Parameter GAP_CYCLES, default 2: number of idle-high sin cycles inserted after every frame.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  1  command request present.
REQ-005 req_ready  output  1  block can accept a command this cycle.
REQ-006 a  input  32  operand A.
REQ-007 b  input  32  operand B.
REQ-008 op  input  3  operation code, operation_t encoding (and 000, or 001, add 100, sub 101; others sent unchanged).
REQ-009 n_data  input  4  number of DATA packets to send; nominal 8.
REQ-010 crc_flip  input  1  when 1, transmitted CRC is bitwise inverted (error injection).
REQ-011 sin  output  1  serial stream to the ALU's serial input.
REQ-012 busy  output  1  frame in progress (accepted, not yet finished including gap).
REQ-013 done  output  1  one-cycle pulse on the last gap cycle of a frame.

Function
REQ-014 Handshake: command accepted on a rising edge where req_valid && req_ready; a, b, op, n_data, crc_flip captured into internal registers at that edge.
REQ-015 req_ready = 1 only in IDLE; inputs ignored while req_ready = 0.
REQ-016 Packet = 11 bits, one per clk, in order: start 0, type bit (0 DATA, 1 CMD), 8 payload bits MSB first, stop 1.
REQ-017 DATA payload sequence: b[31:24], b[23:16], b[15:8], b[7:0], a[31:24], a[23:16], a[15:8], a[7:0]; the first min(n_data,8) bytes of this sequence are sent.
REQ-018 n_data values 9..15 behave as 8; n_data = 0 sends the CMD packet only.
REQ-019 CMD payload = {1'b0, op[2:0], crc[3:0]}, crc XOR 4'hF when captured crc_flip = 1.
REQ-020 crc = CRC-4, polynomial x^4+x+1, init 4'h0, over 68-bit message {b, a, 1'b1, op}, MSB first; always computed over the full operands regardless of n_data.
REQ-021 CRC computed in IDLE->LOAD cycle (combinational or bit-serial); shall be ready before the CMD packet starts.
REQ-022 FSM states: IDLE, LOAD, SEND_DATA, SEND_CTL, GAP.
REQ-023 IDLE -> LOAD on accept; LOAD -> SEND_DATA if effective n_data > 0 else SEND_CTL; SEND_DATA -> SEND_CTL after the last DATA packet's stop bit; SEND_CTL -> GAP after its stop bit; GAP -> IDLE after GAP_CYCLES cycles.
REQ-024 LOAD lasts exactly 1 cycle with sin = 1; first start bit driven in the cycle after LOAD (2 cycles after acceptance edge).
REQ-025 Packets within a frame are back-to-back: no idle bit between a stop bit and the next start bit.
REQ-026 Frame length in bits = 11 * (effective n_data + 1); total accept-to-ready = 1 + frame length + GAP_CYCLES cycles.
REQ-027 sin = 1 in IDLE, LOAD and GAP; sin is registered (no glitches).
REQ-028 busy = 1 in LOAD, SEND_DATA, SEND_CTL, GAP; 0 in IDLE.
REQ-029 done asserted exactly once per frame, in the final GAP cycle; req_ready rises the following cycle.
REQ-030 GAP_CYCLES = 0: done asserted in the cycle carrying the CMD stop bit; next frame's LOAD may follow immediately.

Reset
REQ-031 rst_n low: immediately (asynchronously) sin = 1, busy = 0, done = 0, req_ready = 0, FSM = IDLE, bit/packet counters = 0.
REQ-032 req_ready = 1 from the first clock edge after rst_n deasserts.
REQ-033 Reset mid-frame aborts the frame; no done pulse; partial frame is not resumed.

Verification
REQ-034 add: a=32'h0000_0001, b=32'h0000_0002, op=100, n_data=8, GAP=2 -> 99 frame bits, 8 DATA packets 00,00,00,02,00,00,00,01, CMD payload {0,100,crc} matching reference-model CRC; done 102 cycles after accept.
REQ-035 crc_flip=1 with same operands -> identical stream except CMD crc nibble inverted.
REQ-036 n_data=3 -> DATA packets b[31:24..15:8] only, CMD packet unchanged CRC (full-operand), 44 frame bits.
REQ-037 n_data=0 and n_data=12 -> CMD-only frame (11 bits) and full 8-DATA frame respectively.
REQ-038 req_valid held high continuously with changing a -> each frame carries the value present at its accept edge; inputs changed while busy have no effect.
REQ-039 rst_n pulsed low during bit 5 of third DATA packet -> sin = 1 same cycle, no done, next accepted command sends a complete frame.
